// File: rtl/ext_mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// ext_mem_arbiter_pkg
// Shared definitions for the external memory arbiter that sits between the
// I-cache / D-cache L1 controllers and the single 256-bit external memory port.
// Contents:
//   - state_e        : arbiter FSM state encoding
//   - PORT_I/PORT_D  : requester identifiers used for grant bookkeeping
//   - *_WIDTH_DEF    : default bus widths
// ----------------------------------------------------------------------------
package ext_mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 32;
  localparam int unsigned LINE_WIDTH_DEF = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/ext_mem_arbiter_rr_arbiter2.sv
// ----------------------------------------------------------------------------
// rr_arbiter2
// Combinational two-way round-robin pick.
// Ports:
//   req0, req1  in  : pending requests (port 0 = I-cache, port 1 = D-cache)
//   last_grant  in  : id of the port served most recently
//   gnt_valid   out : at least one request is pending
//   gnt_id      out : id of the port to serve
// A lone request is always granted; on a conflict the port that was not
// served last wins.
// ----------------------------------------------------------------------------
module rr_arbiter2
  import ext_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = PORT_I;
    if (req0 && req1) begin
      gnt_id = ~last_grant;
    end else if (req1) begin
      gnt_id = PORT_D;
    end
  end

endmodule

// File: rtl/ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ext_mem_arbiter
// Shares one external memory line port between the I-cache (port 0) and the
// D-cache (port 1). One whole-line read or write is in flight at a time; the
// granted port receives a one-cycle ack (plus err on timeout) and, for reads,
// the returned line on its rdata bus.
// Ports:
//   clk, rst                    : clock (rising edge), async active-low reset
//   reqN_cs/we/addr/wdata   in  : level request from cache N, held until ack
//   reqN_rdata              out : last line read for cache N
//   reqN_ack                out : one-cycle completion pulse for cache N
//   err                     out : pulses with ack when the access timed out
//   mem_cs/we/addr/data_o   out : external memory request (addr line-aligned)
//   mem_data_i, mem_ack     in  : external memory read line / completion pulse
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module ext_mem_arbiter
  import ext_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEF,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_cs,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [LINE_WIDTH-1:0] req0_wdata,
  output logic [LINE_WIDTH-1:0] req0_rdata,
  output logic                  req0_ack,
  input  logic                  req1_cs,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [LINE_WIDTH-1:0] req1_wdata,
  output logic [LINE_WIDTH-1:0] req1_rdata,
  output logic                  req1_ack,
  output logic                  err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_data_o,
  input  logic [LINE_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_id_q, gnt_id_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_cs_q, mem_cs_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [LINE_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [LINE_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  err_q, err_d;

  logic                  gnt_valid;
  logic                  gnt_id;
  logic                  sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [LINE_WIDTH-1:0] sel_wdata;
  logic                  timed_out;

  rr_arbiter2 u_rr (
    .req0       (req0_cs),
    .req1       (req1_cs),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  assign sel_we    = (gnt_id == PORT_D) ? req1_we    : req0_we;
  assign sel_addr  = (gnt_id == PORT_D) ? req1_addr  : req0_addr;
  assign sel_wdata = (gnt_id == PORT_D) ? req1_wdata : req0_wdata;

  // A late mem_ack on the final counted cycle still counts as success.
  assign timed_out = (cnt_q == CNT_LAST) && !mem_ack;

  // State and datapath registers; reset clears every output, including the
  // rdata buses, and abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_I;
      gnt_id_q     <= PORT_I;
      cnt_q        <= '0;
      mem_cs_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      cnt_q        <= cnt_d;
      mem_cs_q     <= mem_cs_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_valid) state_d = BUSY;
      BUSY:    if (mem_ack || timed_out) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs and bookkeeping. Acks and err default low so they are
  // single-cycle pulses; the DONE cycle gives requesters time to drop cs.
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    cnt_d        = cnt_q;
    mem_cs_d     = mem_cs_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          mem_cs_d   = 1'b1;
          mem_we_d   = sel_we;
          mem_addr_d = {sel_addr[ADDR_WIDTH-1:5], 5'b0};
          mem_data_d = sel_wdata;
          gnt_id_d   = gnt_id;
          cnt_d      = '0;
        end
      end
      BUSY: begin
        if (mem_ack || timed_out) begin
          if (mem_ack && !mem_we_q) begin
            if (gnt_id_q == PORT_D) rdata1_d = mem_data_i;
            else                    rdata0_d = mem_data_i;
          end
          ack0_d       = (gnt_id_q == PORT_I);
          ack1_d       = (gnt_id_q == PORT_D);
          err_d        = timed_out;
          last_grant_d = gnt_id_q;
          // Drop the whole memory request so the idle bus reads as zero.
          mem_cs_d     = 1'b0;
          mem_we_d     = 1'b0;
          mem_addr_d   = '0;
          mem_data_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;
  assign req0_ack   = ack0_q;
  assign req1_ack   = ack1_q;
  assign err        = err_q;
  assign mem_cs     = mem_cs_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_data_o = mem_data_q;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_ext_mem_arbiter
// Bench for ext_mem_arbiter. The bench plays both cache controllers and the
// external memory. A transaction-level reference (round-robin choice, last
// line returned per port) predicts grant order, the memory request fields,
// ack/err and the rdata buses.
// ----------------------------------------------------------------------------
module tb_ext_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    cs  = 2'b00;
  logic [1:0]    we  = 2'b00;
  logic [AW-1:0] addr [2];
  logic [LW-1:0] wd   [2];
  logic [LW-1:0] rd0, rd1, mem_data_o;
  logic [LW-1:0] mem_data_i = '0;
  logic          ack0, ack1, err, mem_cs, mem_we;
  logic          mem_ack = 1'b0;
  logic [AW-1:0] mem_addr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: who was served last, and the line each port last read.
  bit            m_last;
  logic [LW-1:0] m_rd [2];

  always #5 clk = ~clk;

  ext_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_cs    (cs[0]),
    .req0_we    (we[0]),
    .req0_addr  (addr[0]),
    .req0_wdata (wd[0]),
    .req0_rdata (rd0),
    .req0_ack   (ack0),
    .req1_cs    (cs[1]),
    .req1_we    (we[1]),
    .req1_addr  (addr[1]),
    .req1_wdata (wd[1]),
    .req1_rdata (rd1),
    .req1_ack   (ack1),
    .err        (err),
    .mem_cs     (mem_cs),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_ack    (mem_ack)
  );

  task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    v = '0;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serve the request the round-robin rule picks among the asserted cs lines.
  // d = cycle (1-based, counted from the grant) on which memory acks; d == 0 or
  // d > TO means memory never acks and the access must time out after TO
  // cycles in BUSY.
  task automatic serve(input int d, input bit drop, input bit fix, input logic [LW-1:0] fline);
    int            p;
    int            lat;
    int            fin;
    bit            exp_err;
    bit            stable;
    logic [LW-1:0] line;
    if (cs[0] && cs[1]) p = m_last ? 0 : 1;
    else                p = cs[1] ? 1 : 0;
    lat = 0;
    do begin
      step();
      lat++;
    end while (mem_cs !== 1'b1 && lat < 8);
    chk("grant_latency", lat, 1);
    if (mem_cs !== 1'b1) begin
      cs = 2'b00;
      return;
    end
    chk("mem_we", mem_we, we[p]);
    chk("mem_addr", mem_addr, {addr[p][AW-1:5], 5'b0});
    chk("mem_data_o", mem_data_o, wd[p]);
    chk("ack_at_grant", {err, ack1, ack0}, 3'b000);
    exp_err = !(d >= 1 && d <= TO);
    fin     = exp_err ? TO : d;
    stable  = 1'b1;
    line    = '0;
    for (int j = 1; j <= fin; j++) begin
      line       = (fix && j == d) ? fline : rand_line();
      mem_data_i = line;
      mem_ack    = (j == d);
      if (drop && j == 1) cs[p] = 1'b0;
      step();
      mem_ack = 1'b0;
      if (j < fin) begin
        if (!(mem_cs === 1'b1 && mem_we === we[p] && mem_addr === {addr[p][AW-1:5], 5'b0} &&
              mem_data_o === wd[p] && ack0 === 1'b0 && ack1 === 1'b0 && err === 1'b0))
          stable = 1'b0;
      end
    end
    chk("busy_stable", stable, 1'b1);
    if (!exp_err && !we[p]) m_rd[p] = line;
    chk("ack0", ack0, (p == 0));
    chk("ack1", ack1, (p == 1));
    chk("err", err, exp_err);
    chk("cs_after_ack", mem_cs, 1'b0);
    chk("rdata0", rd0, m_rd[0]);
    chk("rdata1", rd1, m_rd[1]);
    cs[p]  = 1'b0;
    m_last = (p == 1);
    step();
    chk("pulse_clear", {mem_cs, err, ack1, ack0}, 4'b0000);
    chk("idle_mem_addr", mem_addr, '0);
  endtask

  task automatic set_req(input int p, input bit w, input logic [AW-1:0] a, input logic [LW-1:0] dat);
    we[p]   = w;
    addr[p] = a;
    wd[p]   = dat;
    cs[p]   = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r, d;
    addr[0] = '0; addr[1] = '0;
    wd[0]   = '0; wd[1]   = '0;
    m_last  = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", {mem_cs, mem_we, err, ack1, ack0}, 5'b00000);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_data", mem_data_o, '0);
    chk("rst_rdata0", rd0, '0);
    chk("rst_rdata1", rd1, '0);
    rst = 1'b1;

    // First conflict after reset: D-cache first, then I-cache; then repeat
    set_req(0, 1'b0, 32'h0000_0100, rand_line());
    set_req(1, 1'b1, 32'h0000_0200, rand_line());
    serve(2, 0, 0, '0);
    serve(3, 0, 0, '0);
    set_req(0, 1'b0, 32'h0000_0100, rand_line());
    set_req(1, 1'b1, 32'h0000_0200, rand_line());
    serve(1, 0, 0, '0);
    serve(2, 0, 0, '0);

    // Single D-cache read with a fixed returned line
    set_req(1, 1'b0, 32'h0000_0424, '0);
    serve(3, 0, 1, {32{8'hA5}});

    // I-cache write-back: rdata must not change
    set_req(0, 1'b1, 32'h0000_0340, {8{32'h1234_5678}});
    serve(2, 0, 0, '0);

    // Timeout, then mem_ack on the very timeout cycle
    set_req(0, 1'b0, 32'h0000_0800, '0);
    serve(0, 0, 0, '0);
    set_req(1, 1'b0, 32'h0000_0900, '0);
    serve(TO, 0, 0, '0);

    // cs dropped during BUSY still completes
    set_req(0, 1'b0, 32'h0000_0A40, '0);
    serve(4, 1, 0, '0);

    // Spurious mem_ack in IDLE
    mem_data_i = rand_line();
    mem_ack    = 1'b1;
    step();
    mem_ack = 1'b0;
    step();
    chk("spur_ctl", {mem_cs, err, ack1, ack0}, 4'b0000);
    chk("spur_rdata0", rd0, m_rd[0]);
    chk("spur_rdata1", rd1, m_rd[1]);

    // Reset two cycles into BUSY
    set_req(1, 1'($urandom_range(0, 1)), $urandom(), rand_line());
    step();
    chk("rst_pre_cs", mem_cs, 1'b1);
    step();
    step();
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_ctl", {mem_cs, mem_we, err, ack1, ack0}, 5'b00000);
    chk("rst_mid_addr", mem_addr, '0);
    chk("rst_mid_rdata0", rd0, '0);
    chk("rst_mid_rdata1", rd1, '0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    m_last  = 1'b0;
    m_rd[0] = '0; m_rd[1] = '0;
    chk("rst_no_ack", {err, ack1, ack0}, 3'b000);
    serve(2, 0, 0, '0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      r = $urandom_range(1, 3);
      if (r[0]) set_req(0, 1'($urandom_range(0, 1)), $urandom(), rand_line());
      if (r[1]) set_req(1, 1'($urandom_range(0, 1)), $urandom(), rand_line());
      while (cs != 2'b00) begin
        r = $urandom_range(0, 19);
        d = (r == 0) ? 0 : (r == 1) ? TO : $urandom_range(1, 6);
        serve(d, 1'($urandom_range(0, 7) == 0), 0, '0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_mem_arbiter.md
Name: ext_mem_arbiter

Overview:
- Shares the single external memory port (256-bit line bus) between the instruction L1 cache (port 0) and the data L1 cache (port 1).
- Each L1 cache controller issues whole-line read (refill) or write (write-back) transactions. The arbiter grants one requester at a time, forwards its transaction to memory, and returns the line plus a one-cycle ack.
- Sits between the two L1 cache controllers and the external memory model, replacing the direct cs/we/addr/data hookup.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- LINE_WIDTH, 256, cache line width in bits (8 words).
- TIMEOUT, 64, max cycles to wait for mem_ack before aborting with error; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- req0_cs  in  1  I-cache request, level, held until ack.
- req0_we  in  1  I-cache write (1) / read (0).
- req0_addr  in  ADDR_WIDTH  I-cache line address.
- req0_wdata  in  LINE_WIDTH  I-cache write line.
- req0_rdata  out  LINE_WIDTH  read line to I-cache.
- req0_ack  out  1  I-cache transaction complete, 1-cycle pulse.
- req1_cs, req1_we, req1_addr, req1_wdata, req1_rdata, req1_ack: same as port 0, for the D-cache.
- err  out  1  1-cycle pulse with ack when the transaction timed out.
- mem_cs  out  1  external memory request.
- mem_we  out  1  external memory write.
- mem_addr  out  ADDR_WIDTH  external address, low 5 bits forced to 0.
- mem_data_o  out  LINE_WIDTH  write line to memory.
- mem_data_i  in  LINE_WIDTH  read line from memory.
- mem_ack  in  1  memory completion, 1-cycle pulse.

Behaviour:
- All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, last_grant=0 (I-cache), counter=0, every output 0 including both rdata buses.
- FSM states:
  - IDLE: sample req0_cs/req1_cs.
    - Only one request asserted: grant it.
    - Both asserted: grant the port that is not last_grant (round-robin), so the D-cache wins the first conflict after reset.
    - On grant, at the edge:
      - latch we, addr (addr[4:0] cleared) and wdata of the granted port into the mem_* registers;
      - set mem_cs=1;
      - record gnt_id;
      - clear the counter;
      - go to BUSY.
    - No request: stay in IDLE, all mem_* held at 0.
  - BUSY: mem_cs stays 1 and the mem_* fields are held stable. Granted-port inputs are not re-sampled.
    - mem_ack=1: latch mem_data_i into reqN_rdata (reads only; writes leave rdata unchanged), pulse reqN_ack, set mem_cs=0, last_grant=gnt_id, go to DONE.
    - Counter reaches TIMEOUT-1 with no mem_ack: pulse reqN_ack and err, set mem_cs=0, leave rdata unchanged, last_grant=gnt_id, go to DONE.
    - Otherwise increment the counter.
  - DONE: one cycle. Acks and err clear, then return to IDLE. This gives the requester one cycle to drop cs. A cs still high in IDLE afterwards is treated as a new request.
- Latency: request seen in IDLE at edge N → mem_cs=1 after edge N. mem_ack sampled at edge M → ack visible after edge M. Minimum req→ack is 2 cycles. Minimum back-to-back ack spacing is 3 cycles.
- mem_ack outside BUSY is ignored.
- mem_ack on the same edge as the timeout: mem_ack wins, err=0.
- reqN_cs dropped during BUSY: the transaction completes anyway and the ack is still pulsed.
- Reset during BUSY: the transaction is abandoned, mem_cs drops immediately, and no ack is issued.
- Fairness: an unbroken D-cache write-back followed by refill is not guaranteed. A pending I-cache request may be served between them.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'd0, BUSY=2'd1, DONE=2'd2;
  - port id constants: PORT_I=1'b0, PORT_D=1'b1;
  - LINE_WIDTH and ADDR_WIDTH defaults.
- One natural sub-module, rr_arbiter2: a combinational 2-way round-robin pick from two requests plus last_grant, producing gnt_valid and gnt_id.
- The FSM, counter and datapath registers stay in ext_mem_arbiter.

Test Plan:
- Single read: req1_cs=1, we=0, addr=0x0000_0424, memory returns 0xA5..A5 with mem_ack 3 cycles after mem_cs → mem_addr=0x0000_0420, req1_rdata=0xA5..A5, req1_ack one pulse 1 cycle after mem_ack, req0_ack stays 0.
- Simultaneous requests after reset: req0 read 0x100, req1 write 0x200 → D-cache served first (mem_we=1, mem_addr=0x200), then I-cache (mem_addr=0x100). Repeat the conflict → order alternates.
- Write: req0_we=1, wdata=0x1234..., mem_ack → mem_data_o matches wdata throughout BUSY, req0_rdata unchanged, err=0.
- Timeout: grant a request and never assert mem_ack → after TIMEOUT=64 cycles in BUSY, ack and err pulse together, mem_cs=0, FSM returns to IDLE. mem_ack on the timeout edge instead → err=0.
- Reset mid-transaction: rst=0 two cycles into BUSY → all outputs 0 asynchronously, no ack. After release, held req1_cs is granted anew.
- Spurious mem_ack in IDLE and a cs drop during BUSY → no state change / ack still delivered, respectively.
